// File: rtl/add_sub_seq_pkg.sv
// add_sub_seq_pkg -- shared definitions for the nibble-serial add/subtract unit.
// Holds the FSM state encoding, the op encodings and the nibble width used by
// add_sub_seq and nibble_addsub.
package add_sub_seq_pkg;

  // Width of one serial digit slice.
  localparam int NIB_W = 4;

  // Operation encodings on the op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_addsub.sv
// nibble_addsub -- combinational 4-bit add/subtract slice with optional BCD adjust.
// Configuration: decimal adjust exists only when ADD_SUB_SEQ_BCD_EN is defined;
// otherwise i_dec is ignored and the slice is a pure binary adder.
// Ports:
//   i_a, i_b  in  4  operand digits
//   i_ci      in  1  carry in (subtract: 1 = no borrow)
//   i_sub     in  1  1 = subtract (b is inverted)
//   i_dec     in  1  1 = decimal adjust the digit
//   o_sum     out 4  adjusted digit result
//   o_bin     out 4  binary result before any decimal adjust (feeds overflow)
//   o_co      out 1  carry out (subtract: 1 = no borrow)
module nibble_addsub
  import add_sub_seq_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_ci,
  input  logic             i_sub,
  input  logic             i_dec,
  output logic [NIB_W-1:0] o_sum,
  output logic [NIB_W-1:0] o_bin,
  output logic             o_co
);

  logic [NIB_W-1:0] w_b_eff;
  logic [NIB_W:0]   w_raw;

  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign w_raw   = {1'b0, i_a} + {1'b0, w_b_eff} + {{NIB_W{1'b0}}, i_ci};
  assign o_bin   = w_raw[NIB_W-1:0];

`ifdef ADD_SUB_SEQ_BCD_EN
  // Decimal correction: add 6 on digit overflow, subtract 6 on digit borrow.
  always_comb begin
    o_sum = w_raw[NIB_W-1:0];
    o_co  = w_raw[NIB_W];
    if (i_dec && !i_sub) begin
      if (w_raw[NIB_W] || (w_raw[NIB_W-1:0] > 4'd9)) begin
        o_sum = w_raw[NIB_W-1:0] + 4'd6;
        o_co  = 1'b1;
      end else begin
        o_sum = w_raw[NIB_W-1:0];
        o_co  = 1'b0;
      end
    end else if (i_dec && i_sub) begin
      // In subtract the raw carry already means "no borrow".
      if (!w_raw[NIB_W]) begin
        o_sum = w_raw[NIB_W-1:0] - 4'd6;
      end else begin
        o_sum = w_raw[NIB_W-1:0];
      end
    end else begin
      o_sum = w_raw[NIB_W-1:0];
    end
  end
`else
  // Binary-only build: the decimal request has no effect.
  logic w_unused_dec;
  assign w_unused_dec = i_dec;
  assign o_sum        = w_raw[NIB_W-1:0];
  assign o_co         = w_raw[NIB_W];
`endif

endmodule

// File: rtl/add_sub_seq.sv
// add_sub_seq -- nibble-serial ADC/SBC unit (6502-style flags), one digit per cycle.
// A start seen while not busy latches the operands; the unit then walks the
// operand LSB digit first through nibble_addsub, chaining the carry through a
// register, and publishes result and flags with a one-cycle done pulse.
// Configuration: define ADD_SUB_SEQ_BCD_EN to enable decimal (dec=1) adjust.
// WIDTH must be a multiple of 4.
// Ports:
//   clk     in  1      clock, rising edge
//   reset   in  1      synchronous active-high reset
//   start   in  1      request, accepted when busy=0
//   op      in  1      0 = add, 1 = subtract
//   dec     in  1      1 = decimal mode
//   a, b    in  WIDTH  operands
//   ci      in  1      carry in (subtract: 1 = no borrow)
//   busy    out 1      high while digits are being processed
//   done    out 1      one-cycle pulse when results update
//   res     out WIDTH  result
//   co, vo, no, zo out 1 carry, overflow, negative, zero flags
module add_sub_seq
  import add_sub_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             dec,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             co,
  output logic             vo,
  output logic             no,
  output logic             zo
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic             r_dec;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_res;
  logic             r_co;
  logic             r_vo;
  logic             r_no;
  logic             r_zo;

  logic [NIB_W-1:0] w_a_nib;
  logic [NIB_W-1:0] w_b_nib;
  logic [NIB_W-1:0] w_sum;
  logic [NIB_W-1:0] w_bin;
  logic             w_nib_co;
  logic             w_last;
  logic             w_accept;
  logic             w_b_eff_top;
  logic             w_vo;
  logic [WIDTH-1:0] w_acc_next;

  assign w_a_nib  = r_a[r_cnt*NIB_W +: NIB_W];
  assign w_b_nib  = r_b[r_cnt*NIB_W +: NIB_W];
  assign w_last   = (r_cnt == CNT_W'(NIB - 1));
  // A new request is taken in IDLE and also in FIN, allowing back-to-back ops.
  assign w_accept = start && ((r_state == IDLE) || (r_state == FIN));

  nibble_addsub u_nib (
    .i_a   (w_a_nib),
    .i_b   (w_b_nib),
    .i_ci  (r_carry),
    .i_sub (r_op == OP_SUB),
    .i_dec (r_dec),
    .o_sum (w_sum),
    .o_bin (w_bin),
    .o_co  (w_nib_co)
  );

  // Overflow uses the pre-adjust top digit and the effective (possibly inverted) b sign.
  assign w_b_eff_top = r_b[WIDTH-1] ^ (r_op == OP_SUB);
  assign w_vo        = (r_a[WIDTH-1] == w_b_eff_top) && (w_bin[NIB_W-1] != r_a[WIDTH-1]);

  // Merge the current digit into the result accumulator.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_cnt*NIB_W +: NIB_W] = w_sum;
  end

  // Sequencer, operand capture and registered result/flag outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_dec   <= 1'b0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_co    <= 1'b0;
      r_vo    <= 1'b0;
      r_no    <= 1'b0;
      r_zo    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_op    <= op;
        r_dec   <= dec;
        r_carry <= ci;
        r_cnt   <= '0;
        r_acc   <= '0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        CALC: begin
          r_acc   <= w_acc_next;
          r_carry <= w_nib_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_res   <= w_acc_next;
            r_co    <= w_nib_co;
            r_vo    <= w_vo;
            r_no    <= w_acc_next[WIDTH-1];
            r_zo    <= (w_acc_next == '0);
          end else begin
            r_state <= CALC;
            r_busy  <= 1'b1;
          end
        end
        FIN: begin
          if (w_accept) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign res  = r_res;
  assign co   = r_co;
  assign vo   = r_vo;
  assign no   = r_no;
  assign zo   = r_zo;

endmodule

// File: tb/tb_add_sub_seq.sv
// tb_add_sub_seq -- scoreboard bench for add_sub_seq: stimulus pushes the
// expected result from an arithmetic reference model, a monitor pops on done.
// Decimal expectations apply only when ADD_SUB_SEQ_BCD_EN is defined.
module tb_add_sub_seq;

  localparam int WIDTH = 8;
  localparam int NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             vo;
    logic             no;
    logic             zo;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             op;
  logic             dec;
  logic             ci;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             co;
  logic             vo;
  logic             no;
  logic             zo;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  add_sub_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .dec   (dec),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .res   (res),
    .co    (co),
    .vo    (vo),
    .no    (no),
    .zo    (zo)
  );

  // Reference: whole-word arithmetic for binary, digit-by-digit rules for decimal.
  function automatic exp_t model(input logic op_i, input logic dec_i,
                                 input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                 input logic ci_i);
    exp_t e;
    int ai, bi, c, opi, s, sa, sb, r, da, db, t, d, bin, a_top, b_top;
    bit bcd;
    ai  = int'(a_i);
    bi  = int'(b_i);
    c   = ci_i ? 1 : 0;
    opi = op_i ? 1 : 0;
    bcd = 1'b0;
`ifdef ADD_SUB_SEQ_BCD_EN
    bcd = dec_i;
`else
    if (dec_i) bcd = 1'b0;
`endif
    if (!bcd) begin
      s  = ai + (op_i ? ((1 << WIDTH) - 1 - bi) : bi) + c;
      e.res = WIDTH'(s % (1 << WIDTH));
      e.co  = (s >= (1 << WIDTH));
      sa = (ai >= (1 << (WIDTH-1))) ? ai - (1 << WIDTH) : ai;
      sb = (bi >= (1 << (WIDTH-1))) ? bi - (1 << WIDTH) : bi;
      r  = op_i ? (sa - sb - (1 - c)) : (sa + sb + c);
      e.vo = (r > ((1 << (WIDTH-1)) - 1)) || (r < -(1 << (WIDTH-1)));
    end else begin
      r   = 0;
      bin = 0;
      for (int i = 0; i < NIB; i++) begin
        da = (ai >> (4*i)) & 15;
        db = (bi >> (4*i)) & 15;
        if (op_i) begin
          t = da - db - (1 - c);
          if (t < 0) begin d = (t - 6) & 15; c = 0; end
          else begin d = t; c = 1; end
        end else begin
          t = da + db + c;
          if (t > 9) begin d = (t + 6) & 15; c = 1; end
          else begin d = t; c = 0; end
        end
        if (i == NIB - 1) bin = t & 15;
        r = r | (d << (4*i));
      end
      e.res = WIDTH'(r);
      e.co  = (c == 1);
      a_top = (ai >> (WIDTH-1)) & 1;
      b_top = ((bi >> (WIDTH-1)) & 1) ^ opi;
      e.vo  = (a_top == b_top) && (((bin >> 3) & 1) != a_top);
    end
    e.no = e.res[WIDTH-1];
    e.zo = (e.res == '0);
    return e;
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: res=%h with no pending op at %0t", res, $time);
      end else begin
        mon_e = sb_q.pop_front();
        if ({res, co, vo, no, zo} !== mon_e) begin
          n_err++;
          $display("FAIL result: got res=%h co=%b vo=%b no=%b zo=%b expected res=%h co=%b vo=%b no=%b zo=%b",
                   res, co, vo, no, zo, mon_e.res, mon_e.co, mon_e.vo, mon_e.no, mon_e.zo);
        end
      end
    end
  end

  // Issue one request at the current cycle (called #1 after a rising edge).
  // mode 0: normal; 1: re-pulse start while busy; 2: reset at the completion edge.
  task automatic issue(input logic op_i, input logic dec_i, input logic [WIDTH-1:0] a_i,
                       input logic [WIDTH-1:0] b_i, input logic ci_i, input int mode);
    op = op_i; dec = dec_i; a = a_i; b = b_i; ci = ci_i; start = 1'b1;
    if (mode != 2) sb_q.push_back(model(op_i, dec_i, a_i, b_i, ci_i));
    @(posedge clk); #1;
    start = 1'b0;
    // Inputs after the accept edge must not matter.
    {op, dec, ci} = 3'($urandom);
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    chk_bit("accept_busy", busy, 1'b1);
    chk_bit("accept_done", done, 1'b0);
    if (mode == 1) start = 1'b1;
    for (int k = 1; k <= NIB; k++) begin
      if (mode == 2 && k == NIB) reset = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 2 && k == NIB) begin
        reset = 1'b0;
        chk_bit("abort_done", done, 1'b0);
        chk_bit("abort_busy", busy, 1'b0);
        chk_vec("abort_res", res, '0);
        chk_bit("abort_flags", |{co, vo, no, zo}, 1'b0);
      end else if (k < NIB) begin
        chk_bit("calc_busy", busy, 1'b1);
        chk_bit("calc_done", done, 1'b0);
      end else begin
        chk_bit("fin_busy", busy, 1'b0);
        chk_bit("fin_done", done, 1'b1);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; dec = 1'b0; ci = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_vec("rst_res", res, '0);
    chk_bit("rst_flags", |{co, vo, no, zo}, 1'b0);
    // Reset wins over a simultaneous start.
    start = 1'b1;
    @(posedge clk); #1;
    chk_bit("rst_prio_busy", busy, 1'b0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    issue(1'b0, 1'b0, 8'h50, 8'h50, 1'b0, 0);
    issue(1'b1, 1'b0, 8'h50, 8'hF0, 1'b1, 0);   // started in the FIN cycle
    @(posedge clk); #1;
    chk_bit("idle_done", done, 1'b0);
    issue(1'b0, 1'b1, 8'h58, 8'h46, 1'b1, 0);
    issue(1'b1, 1'b1, 8'h12, 8'h21, 1'b1, 0);
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0, 0);
    issue(1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 0);   // back-to-back
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 8'h7F, 8'h01, 1'b0, 1);   // start re-pulsed while busy
    @(posedge clk); #1;
    chk_bit("post_ignore_done", done, 1'b0);
    issue(1'b0, 1'b0, 8'h33, 8'h44, 1'b1, 2);   // reset aborts

    for (int n = 0; n < 200; n++) begin
      logic [2:0] ctl;
      int gap;
      ctl = 3'($urandom);
      gap = $urandom_range(2, 0);
      issue(ctl[0], ctl[1], WIDTH'($urandom), WIDTH'($urandom), ctl[2], 0);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk_bit("queue_drained", sb_q.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Bound the run in case the sequencer stalls.
  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, %0d pending", sb_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
